// File: rtl/md_pkg.sv
// md_pkg: opcode encodings, FSM state type and decode helpers shared with the hazard unit
package md_pkg;
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  typedef enum logic {IDLE, BUSY} md_state_t;

  function automatic logic md_is_mul(input logic [2:0] op);
    return op == MD_MULT || op == MD_MULTU;
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction

  // ops that open a multi-cycle busy window; the hazard unit stalls HI/LO users on these
  function automatic logic md_is_multdiv(input logic [2:0] op);
    return md_is_mul(op) || md_is_div(op);
  endfunction
endpackage

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit product, truncating quotient/remainder and zero-divide flag
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);
  logic        sgn;
  logic [63:0] ae, be;
  logic [31:0] ma, mb, dv, q, r;
  assign sgn      = op == MD_MULT || op == MD_DIV;
  assign ae       = {{32{sgn & a[31]}}, a};
  assign be       = {{32{sgn & b[31]}}, b};
  assign prod     = ae * be;
  assign div_zero = b == 32'd0;
  // divide magnitudes, then restore signs: quotient truncates toward zero, remainder follows dividend
  assign ma       = (sgn && a[31]) ? -a : a;
  assign mb       = (sgn && b[31]) ? -b : b;
  assign dv       = div_zero ? 32'd1 : mb;
  assign q        = ma / dv;
  assign r        = ma % dv;
  assign quot     = (sgn && (a[31] ^ b[31])) ? -q : q;
  assign rem      = (sgn && a[31]) ? -r : r;
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: E-stage mult/div sequencer owning HI/LO, with a fixed-length busy window
module muldiv_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        IntReq,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  md_state_t   state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic [31:0] hi_n, lo_n, hi_d, lo_d, hi_n_d, lo_n_d, quot, rem;
  logic [63:0] prod;
  logic        div_zero, accept;

  md_arith u_arith (
    .op      (op),
    .a       (a),
    .b       (b),
    .prod    (prod),
    .quot    (quot),
    .rem     (rem),
    .div_zero(div_zero)
  );

  // a start alongside IntReq belongs to the flushed instruction and must not touch HI/LO
  assign accept   = start && !IntReq && state == IDLE && op != MD_NONE;
  assign busy     = state == BUSY;
  assign md_stall = busy || (start && md_is_multdiv(op));

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    hi_d    = hi;
    lo_d    = lo;
    hi_n_d  = hi_n;
    lo_n_d  = lo_n;
    if (state == BUSY) begin
      cnt_d = cnt - 4'd1;
      if (cnt == 4'd0) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        hi_d    = hi_n;
        lo_d    = lo_n;
      end
    end else if (accept) begin
      if (md_is_mul(op)) begin
        {hi_n_d, lo_n_d} = prod;
        cnt_d            = 4'(MULT_CYCLES - 1);
        state_d          = BUSY;
      end else if (md_is_div(op)) begin
        hi_n_d  = div_zero ? hi : rem;
        lo_n_d  = div_zero ? lo : quot;
        cnt_d   = 4'(DIV_CYCLES - 1);
        state_d = BUSY;
      end else begin
        hi_d = op == MD_MTHI ? a : hi;
        lo_d = op == MD_MTLO ? a : lo;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      hi    <= hi_d;
      lo    <= lo_d;
      hi_n  <= hi_n_d;
      lo_n  <= lo_n_d;
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl; stimulus and sampling on the falling edge
module tb_muldiv_ctrl;
  import md_pkg::*;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 0, reset_n = 0, start = 0, int_req = 0;
  logic [2:0]  op = MD_NONE;
  logic [31:0] a = 0, b = 0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] sb[$];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .IntReq  (int_req),
    .busy    (busy),
    .md_stall(md_stall),
    .hi      (hi),
    .lo      (lo)
  );

  always @(posedge clk)
    if (reset_n && busy && start) begin
      checks++;
      errors++;
      $display("FAIL start_while_busy: start seen with busy=1 at %0t", $time);
    end

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, y, h, l);
    longint p;
    int q, r;
    case (o)
      MD_MULT:  begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      MD_MULTU: return {32'd0, x} * {32'd0, y};
      MD_DIV:   begin
        if (y == 0) return {h, l};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      MD_DIVU:  return (y == 0) ? {h, l} : {x % y, x / y};
      default:  return {h, l};
    endcase
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, y, input logic irq);
    logic lng;
    lng = (o == MD_MULT || o == MD_MULTU || o == MD_DIV || o == MD_DIVU);
    start = 1; op = o; a = x; b = y; int_req = irq;
    #1;
    checks++;
    if (md_stall !== lng)
      begin errors++; $display("FAIL issue_md_stall op=%0d: got %b want %b", o, md_stall, lng); end
    checks++;
    if (busy !== 1'b0)
      begin errors++; $display("FAIL issue_busy op=%0d: got %b want 0", o, busy); end
    @(negedge clk);
    start = 0; op = MD_NONE; int_req = 0;
  endtask

  task automatic run_md(input logic [2:0] o, input logic [31:0] x, y, input int irq_at);
    logic [63:0] exp;
    int n, want;
    sb.push_back(model(o, x, y, m_hi, m_lo));
    want = (o == MD_MULT || o == MD_MULTU) ? MC : DC;
    issue(o, x, y, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      checks++;
      if ({hi, lo} !== {m_hi, m_lo})
        begin errors++; $display("FAIL early_update op=%0d cyc=%0d: got %h want %h", o, n, {hi, lo}, {m_hi, m_lo}); end
      int_req = (n == irq_at);
      n++;
      @(negedge clk);
    end
    int_req = 0;
    checks++;
    if (n != want) begin errors++; $display("FAIL busy_len op=%0d: got %0d want %0d", o, n, want); end
    exp = sb.pop_front();
    checks++;
    if ({hi, lo} !== exp)
      begin errors++; $display("FAIL result op=%0d a=%h b=%h: got %h want %h", o, x, y, {hi, lo}, exp); end
    {m_hi, m_lo} = exp;
  endtask

  task automatic move(input logic [2:0] o, input logic [31:0] x);
    issue(o, x, 32'd0, 1'b0);
    if (o == MD_MTHI) m_hi = x; else m_lo = x;
    checks++;
    if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
      begin errors++; $display("FAIL move op=%0d: got busy=%b %h want busy=0 %h", o, busy, {hi, lo}, {m_hi, m_lo}); end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, md_stall, hi, lo} !== 66'd0)
      begin errors++; $display("FAIL reset: got busy=%b stall=%b hi=%h lo=%h want all 0", busy, md_stall, hi, lo); end
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    run_md(MD_MULT, 32'hFFFFFFFD, 32'd7, -1);
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_vec: got %h", {hi, lo}); end
    run_md(MD_MULTU, 32'hFFFFFFFF, 32'd2, -1);
    checks++;
    if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin errors++; $display("FAIL multu_vec: got %h", {hi, lo}); end
  endtask

  task automatic test_div();
    run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, -1);
    checks++;
    if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_vec: got %h", {hi, lo}); end
    move(MD_MTHI, 32'h11);
    move(MD_MTLO, 32'h22);
    run_md(MD_DIVU, 32'd9, 32'd0, -1);
    checks++;
    if ({hi, lo} !== 64'h00000011_00000022) begin errors++; $display("FAIL divzero_vec: got %h", {hi, lo}); end
  endtask

  task automatic test_mthi();
    move(MD_MTHI, 32'hDEADBEEF);
    checks++;
    if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_vec: got %h want deadbeef", hi); end
  endtask

  task automatic test_interrupt();
    issue(MD_MULT, 32'd3, 32'd4, 1'b1);
    repeat (MC + 1) begin
      checks++;
      if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
        begin errors++; $display("FAIL int_drop: got busy=%b %h want busy=0 %h", busy, {hi, lo}, {m_hi, m_lo}); end
      @(negedge clk);
    end
    run_md(MD_DIV, 32'd100, 32'hFFFFFFF9, 3);
  endtask

  task automatic test_back_to_back();
    logic [2:0] o;
    logic [31:0] x, y;
    run_md(MD_MULT, 32'h12345678, 32'h9ABCDEF0, -1);
    run_md(MD_MULTU, 32'h89ABCDEF, 32'hFEDCBA98, -1);
    for (int i = 0; i < 6; i++) begin
      o = 3'($urandom_range(1, 4));
      x = $urandom;
      y = $urandom;
      if (y == 0 || (o == MD_DIV && x == 32'h80000000 && y == 32'hFFFFFFFF)) y = 32'd3;
      run_md(o, x, y, -1);
    end
  endtask

  task automatic test_reset_mid();
    issue(MD_MULT, 32'd5, 32'd6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 0;
    #1;
    checks++;
    if ({busy, hi, lo} !== 65'd0)
      begin errors++; $display("FAIL async_reset: got busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
    @(negedge clk);
    reset_n = 1;
    m_hi = 0; m_lo = 0;
    sb.delete();
    repeat (MC + 1) @(negedge clk);
    checks++;
    if ({busy, hi, lo} !== 65'd0)
      begin errors++; $display("FAIL reset_discard: got busy=%b hi=%h lo=%h want 0", busy, hi, lo); end
    run_md(MD_MULT, 32'd5, 32'd6, -1);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi();
    test_interrupt();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. It accepts one mult/multu/div/divu/mthi/mtlo per issue, owns the HI/LO registers, and holds a multi-cycle busy window that the hazard unit uses to stall any HI/LO-touching instruction in D. It drops starts that coincide with an interrupt, so a flushed E-stage instruction never modifies HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  input  1  pipeline clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is an md op (qualified by op)
- op  input  3  md opcode from shared package (MD_NONE/MULT/MULTU/DIV/DIVU/MTHI/MTLO)
- a  input  32  forwarded rs value in E
- b  input  32  forwarded rt value in E
- IntReq  input  1  interrupt/exception taken this cycle; E-stage instruction is being flushed
- busy  output  1  operation in flight; registered
- md_stall  output  1  busy | (start & op is mult/div), for hazard unit
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, BUSY. 4-bit down-counter `cnt`. Result shadow registers `hi_n` and `lo_n`.
- accept = start & !IntReq & state==IDLE & op!=MD_NONE.
- IDLE and accept with MULT/MULTU:
  - {hi_n,lo_n} <= 64-bit product (signed/unsigned).
  - cnt <= MULT_CYCLES-1; go to BUSY.
- IDLE and accept with DIV/DIVU, b!=0:
  - lo_n <= quotient, truncated toward zero.
  - hi_n <= remainder, with the sign of the dividend for signed ops.
  - cnt <= DIV_CYCLES-1; go to BUSY.
- DIV/DIVU with b==0:
  - hi_n <= hi and lo_n <= lo, so HI/LO stay unchanged.
  - Full DIV_CYCLES busy window still applies.
- IDLE and accept with MTHI/MTLO: hi (or lo) <= a on the same edge. No BUSY state entered.
- BUSY:
  - cnt>0: decrement.
  - cnt==0: hi<=hi_n, lo<=lo_n, go to IDLE.
- start while BUSY is ignored. The hazard unit guarantees this never happens, and the bench asserts it.
- IntReq while BUSY does not cancel the operation: its instruction is older than the victim and has committed.
- Reset: state IDLE, cnt 0, busy 0, hi 0, lo 0, hi_n 0, lo_n 0.

## Timing
- busy is registered high exactly while state==BUSY.
- md_stall is combinational and covers the issue cycle. Hazard adds: stall D if md_stall & D is mult/div/mfhi/mflo/mthi/mtlo.
- mult accepted at edge ending cycle t:
  - busy high in cycles t+1..t+MULT_CYCLES.
  - hi/lo show the new value from cycle t+MULT_CYCLES+1.
- div: same rule with DIV_CYCLES.
- mthi/mtlo accepted at cycle t: new value visible at t+1, busy stays 0.
- Back-to-back mult: a second start is accepted in the first cycle busy==0.
- Async reset mid-operation: immediate IDLE, outputs zero, in-flight result discarded.

## Structure
- Shared package md_pkg holds:
  - the MD_* op encodings (3-bit, MD_NONE=0);
  - the md_state_t enum {IDLE, BUSY};
  - the HI/LO-user decode helper used by both this block and the hazard unit.
- One natural sub-module, md_arith: purely combinational 64-bit product, quotient/remainder and zero-divide detection. muldiv_ctrl keeps the FSM, counter and registers.

## Test plan
- mult a=-3 (0xFFFFFFFD), b=7 → busy 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu a=0xFFFFFFFF, b=2 → after 5 cycles hi=1, lo=0xFFFFFFFE.
- div a=-7, b=2 → busy 10 cycles; then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu a=9, b=0 with prior hi=0x11, lo=0x22 → busy 10 cycles; hi/lo remain 0x11/0x22.
- Interrupt cases:
  - mult with IntReq high in the start cycle → busy stays 0 and hi/lo are unchanged.
  - IntReq pulsed mid-div → the div still completes with the correct result.
- mthi a=0xDEADBEEF → hi updates next cycle with busy=0.
- Reset mid-mult:
  - reset_n low during cycle 3 → busy, hi and lo are 0 immediately.
  - After release, a new mult completes normally.
